// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- RAM BIST engine: FSM state encoding,
// address-counter direction codes and state-decode helpers.
package ram_bist_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_M0_W   = 4'd1,
    S_M1_R   = 4'd2,
    S_M1_W   = 4'd3,
    S_M2_R   = 4'd4,
    S_M2_W   = 4'd5,
    S_M3_R   = 4'd6,
    S_M3_CHK = 4'd7,
    S_DONE   = 4'd8
  } bist_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic is_write_state(input bist_state_t s);
    return (s == S_M0_W) || (s == S_M1_W) || (s == S_M2_W);
  endfunction

  function automatic logic is_busy_state(input bist_state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

  function automatic logic is_down_state(input bist_state_t s);
    return (s == S_M2_R) || (s == S_M2_W) || (s == S_M3_R);
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the BIST march elements. last_o flags the
// terminal address for the selected direction (N-1 going up, 0 going down).
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_val_i,
  input  logic                  dir_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (en_i) begin
      addr_d = (dir_i == DIR_DOWN) ? addr_q - 1'b1 : addr_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (dir_i == DIR_DOWN) ? (addr_q == '0) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/ram_bist.sv
// March C- BIST engine for one port of a registered-read, read-before-write
// RAM. Reads are checked one cycle later through a small compare pipeline.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_data_wr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_rd_i
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [DATA_WIDTH-1:0] PAT_Z      = '0;
  localparam logic [DATA_WIDTH-1:0] PAT_O      = '1;

  bist_state_t           state_q, state_d;
  logic                  chk_vld_q, chk_vld_d;
  logic [ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
  logic [DATA_WIDTH-1:0] chk_exp_q, chk_exp_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  logic                  cnt_load;
  logic [ADDR_WIDTH-1:0] cnt_load_val;
  logic                  cnt_en;
  logic                  cnt_dir;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic                  cnt_last;
  logic                  mismatch;

  // Direction comes straight from the state register so that last_o never
  // loops back through the next-state logic.
  assign cnt_dir = is_down_state(state_q) ? DIR_DOWN : DIR_UP;

  ram_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dir_i      (cnt_dir),
    .en_i       (cnt_en),
    .addr_o     (cnt_addr),
    .last_o     (cnt_last)
  );

  assign mismatch = chk_vld_q && (ram_data_rd_i != chk_exp_q);

  // NOTE: every variable written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = ADDR_FIRST;
    cnt_en       = 1'b0;
    chk_vld_d    = 1'b0;
    chk_addr_d   = chk_addr_q;
    chk_exp_d    = chk_exp_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_M0_W;
          cnt_load     = 1'b1;
          cnt_load_val = ADDR_FIRST;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
        end
      end
      S_M0_W: begin
        if (cnt_last) begin
          state_d      = S_M1_R;
          cnt_load     = 1'b1;
          cnt_load_val = ADDR_FIRST;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_M1_R: begin
        chk_vld_d  = 1'b1;
        chk_addr_d = cnt_addr;
        chk_exp_d  = PAT_Z;
        state_d    = S_M1_W;
      end
      S_M1_W: begin
        if (cnt_last) begin
          state_d      = S_M2_R;
          cnt_load     = 1'b1;
          cnt_load_val = ADDR_LAST;
        end else begin
          state_d = S_M1_R;
          cnt_en  = 1'b1;
        end
      end
      S_M2_R: begin
        chk_vld_d  = 1'b1;
        chk_addr_d = cnt_addr;
        chk_exp_d  = PAT_O;
        state_d    = S_M2_W;
      end
      S_M2_W: begin
        if (cnt_last) begin
          state_d      = S_M3_R;
          cnt_load     = 1'b1;
          cnt_load_val = ADDR_LAST;
        end else begin
          state_d = S_M2_R;
          cnt_en  = 1'b1;
        end
      end
      S_M3_R: begin
        chk_vld_d  = 1'b1;
        chk_addr_d = cnt_addr;
        chk_exp_d  = PAT_Z;
        if (cnt_last) begin
          state_d = S_M3_CHK;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_M3_CHK: begin
        state_d = S_DONE;
        pass_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The first mismatch wins over any march progress and freezes the run.
    if (mismatch) begin
      state_d     = S_DONE;
      pass_d      = 1'b0;
      fail_addr_d = chk_addr_q;
      fail_data_d = ram_data_rd_i;
      chk_vld_d   = 1'b0;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      chk_vld_q   <= 1'b0;
      chk_addr_q  <= '0;
      chk_exp_q   <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      chk_vld_q   <= chk_vld_d;
      chk_addr_q  <= chk_addr_d;
      chk_exp_q   <= chk_exp_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy_o        = is_busy_state(state_q);
  assign done_o        = (state_q == S_DONE);
  assign pass_o        = pass_q;
  assign fail_addr_o   = fail_addr_q;
  assign fail_data_o   = fail_data_q;
  assign ram_addr_o    = cnt_addr;
  assign ram_we_o      = is_write_state(state_q);
  assign ram_data_wr_o = (state_q == S_M1_W) ? PAT_O : PAT_Z;

endmodule

// File: doc/ram_bist.md
# ram_bist

March-test built-in self-test engine that drives one port of the team's dual-port `ram` and checks its contents. On `start_i` it runs a March C- style sequence over every address:
- writing background patterns;
- reading them back through the RAM's registered read output;
- reporting pass/fail and the first failing address and read word.

It sits between system control logic and one RAM port. The port is muxed to the BIST while `busy_o` is high.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width; N = 2**ADDR_WIDTH words tested.
- `DATA_WIDTH`, default 8: RAM word width.

- `clk_i`  in  1  single clock; the RAM port under test runs on the same clock.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  begin a test run; sampled only in IDLE or DONE.
- `busy_o`  out  1  test in progress.
- `done_o`  out  1  run finished; level, held until the next accepted start or reset.
- `pass_o`  out  1  valid while `done_o` is high; 1 means no mismatch.
- `fail_addr_o`  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- `fail_data_o`  out  DATA_WIDTH  read word at the first mismatch; 0 if none.
- `ram_addr_o`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_we_o`  out  1  to RAM `we`.
- `ram_data_wr_o`  out  DATA_WIDTH  to RAM write data.
- `ram_data_rd_i`  in  DATA_WIDTH  from RAM registered read output. It holds mem[`ram_addr_o`] as sampled at the previous edge (read-before-write).

## Operation
- Background patterns: Z = all zeros, O = all ones of DATA_WIDTH.
- States: IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_CHK, DONE.
- Accepting `start_i` in IDLE or DONE:
  - sets addr = 0 and clears `done_o`, `pass_o`, `fail_*`;
  - moves to M0_W.
- M0_W, ascending: write Z at addr. When addr = N-1, go to M1_R with addr = 0.
- M1, ascending:
  - M1_R reads addr with expected value Z.
  - M1_W writes O at the same addr.
  - When addr = N-1, go to M2_R with addr = N-1.
- M2, descending:
  - M2_R reads with expected value O.
  - M2_W writes Z.
  - When addr = 0, go to M3_R with addr = N-1.
- M3_R, descending: read with expected value Z. When addr = 0, go to M3_CHK.
- M3_CHK: no RAM access; the last compare completes here. Then go to DONE with `pass_o` = 1.
- Check pipeline: every read state loads `chk_vld`/`chk_addr`/`chk_exp` registers. The next cycle compares `ram_data_rd_i` against `chk_exp`.
- Mismatch handling (first mismatch only):
  - capture `chk_addr` into `fail_addr_o` and `ram_data_rd_i` into `fail_data_o`;
  - abort to DONE with `pass_o` = 0;
  - `ram_we_o` is 0 from the next cycle onward.
- RAM outputs are decoded only from state and counter registers. There is no combinational path from any input to any output.
- `ram_we_o` = 1 only in M0_W, M1_W and M2_W.
- `ram_data_wr_o` = O in M1_W; Z in every other state.
- `busy_o` = 1 in every state except IDLE and DONE.
- `start_i` while busy: ignored.
- `start_i` in DONE: restarts immediately; `done_o` drops at that same edge.
- Reset, at any time including mid-run:
  - state goes to IDLE;
  - all outputs go to 0 at the reset edge;
  - `chk_vld` is cleared;
  - no partial compare is reported.

## Timing
- Edge 0 samples `start_i`; `busy_o` is high after edge 0.
- State occupancy: M0 N cycles, M1 2N, M2 2N, M3_R N, M3_CHK 1.
- For a passing run, `done_o` rises and `busy_o` falls after edge 6N+1.
- Mismatch reporting: the compare for a read issued in cycle k is evaluated in cycle k+1. `done_o` goes high after the edge ending cycle k+1.
- A read in M1_R/M2_R is followed by the write to the same address in the next cycle. The read-before-write RAM guarantees that the compared data is the old value.
- Address counter arithmetic is ADDR_WIDTH-bit. Terminal detection uses an explicit compare to N-1 or 0, never wrap-around.

## Structure
- Package `ram_bist_pkg`:
  - typedef enum `bist_state_t` with the nine states above;
  - localparam widths of the state encoding.
- Natural sub-module `ram_bist_addr_gen`: ADDR_WIDTH up/down counter with `load_i`, `dir_i`, `en_i` and terminal flag `last_o`, selected by direction.
- Top level: FSM, check pipeline and result registers. Bench instantiates `ram` port A against this block.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=8, fault-free RAM, pulse `start_i` -> `done_o` high exactly 97 cycles after the start edge; `pass_o` = 1; `fail_addr_o` = 0x0; `fail_data_o` = 0x00.
- Bit 0 of addr 5 stuck at 1 -> abort during M1; `fail_addr_o` = 5; `fail_data_o` = 0x01; `pass_o` = 0; no writes after the abort.
- Bit 7 of addr 0xE stuck at 0 -> M2_R mismatch; `fail_addr_o` = 0xE; `fail_data_o` = 0x7F; `pass_o` = 0.
- Write-decoder fault where a write to addr 3 also writes addr 4 -> the M1 read of addr 4 sees 0xFF; `fail_addr_o` = 4; `fail_data_o` = 0xFF.
- `rst_i` asserted at cycle 40 of a run -> all outputs 0 next cycle; a new start runs the full 97 cycles and passes.
- `start_i` held high during a run -> ignored; after DONE, `start_i` = 1 restarts and drops `done_o` at that same edge.
